// File: rtl/xnor8_parity_sched.sv
// xnor8_parity_sched: shares one xnor8 byte-reduction unit between two
// requesters. Round-robin grant, then the granted word is folded one byte per
// cycle (LSB byte first) into a parity accumulator and returned with the
// requester ID.
// Optional feature macro: XNOR8_PARITY_SCHED_CHECK_EN (latches an expected
// parity bit per request and flags a mismatch on resp_err).

module xnor8 (
  input  logic [7:0] a_i,
  output logic       y_o
);
  // y is 1 for an even number of ones in the byte
  assign y_o = ~(^a_i);
endmodule

module xnor8_parity_sched #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [8*NBYTES-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [8*NBYTES-1:0] req1_data,
  output logic                req1_ready,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_parity,
  output logic                resp_id,
`ifdef XNOR8_PARITY_SCHED_CHECK_EN
  input  logic                req0_exp,
  input  logic                req1_exp,
  output logic                resp_err,
`endif
  output logic                busy
);

  localparam int DW    = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [DW-1:0]    data_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             acc_q;
  logic             acc_d;
  logic             id_q;
  logic             last_q;       // 1: requester 1 was served last
  logic             resp_valid_q;
  logic             grant0_s;
  logic             grant1_s;
  logic             xfer0_s;
  logic             xfer1_s;
  logic [7:0]       byte_s;
  logic             xnor_y_s;
`ifdef XNOR8_PARITY_SCHED_CHECK_EN
  logic             exp_q;
`endif

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0_s = last_q;
      grant1_s = ~last_q;
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = (state_q == S_IDLE) & grant0_s & ~rst;
  assign req1_ready = (state_q == S_IDLE) & grant1_s & ~rst;
  assign xfer0_s    = req0_ready & req0_valid;
  assign xfer1_s    = req1_ready & req1_valid;

  // The single shared reduction unit sees the byte selected by idx
  assign byte_s = data_q[{idx_q, 3'b000} +: 8];

  xnor8 u_xnor8 (
    .a_i (byte_s),
    .y_o (xnor_y_s)
  );

  assign acc_d = acc_q ^ ~xnor_y_s;
  assign idx_d = idx_q + IDX_W'(1);

  // Scheduler FSM: accept in IDLE, fold bytes in RUN, hold the result in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      idx_q        <= '0;
      acc_q        <= 1'b0;
      id_q         <= 1'b0;
      last_q       <= 1'b1;
      resp_valid_q <= 1'b0;
`ifdef XNOR8_PARITY_SCHED_CHECK_EN
      exp_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer0_s || xfer1_s) begin
            data_q  <= xfer0_s ? req0_data : req1_data;
            id_q    <= xfer1_s;
`ifdef XNOR8_PARITY_SCHED_CHECK_EN
            exp_q   <= xfer0_s ? req0_exp : req1_exp;
`endif
            acc_q   <= 1'b0;
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          idx_q <= idx_d;
          if (idx_q == LAST_IDX) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            last_q       <= id_q;
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Response outputs come straight from registers, forced low while reset is held
  assign resp_valid  = resp_valid_q & ~rst;
  assign resp_parity = resp_valid_q & acc_q & ~rst;
  assign resp_id     = resp_valid_q & id_q & ~rst;
  assign busy        = (state_q != S_IDLE) & ~rst;
`ifdef XNOR8_PARITY_SCHED_CHECK_EN
  assign resp_err    = resp_valid_q & (acc_q ^ exp_q) & ~rst;
`endif

endmodule

// File: tb/tb_xnor8_parity_sched.sv
// Self-checking bench for xnor8_parity_sched: directed test-plan cases plus
// randomized traffic against a ones-counting parity / round-robin model.
module tb_xnor8_parity_sched;

  localparam int NB = 4;
  localparam int DW = 8 * NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          resp_valid, resp_ready, resp_parity, resp_id, busy;
  logic          req0_exp, req1_exp, resp_err;

  logic          v8;
  logic [63:0]   d8;
  logic          rdy8, unused_rdy8b, rv8, rp8, rid8, busy8, err8;

  int n_tests = 0;
  int n_fail  = 0;
  int last_m  = 1;

  xnor8_parity_sched #(.NBYTES(NB)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_parity(resp_parity), .resp_id(resp_id),
`ifdef XNOR8_PARITY_SCHED_CHECK_EN
    .req0_exp(req0_exp), .req1_exp(req1_exp), .resp_err(resp_err),
`endif
    .busy(busy)
  );

  xnor8_parity_sched #(.NBYTES(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(v8), .req0_data(d8), .req0_ready(rdy8),
    .req1_valid(1'b0), .req1_data(64'd0), .req1_ready(unused_rdy8b),
    .resp_valid(rv8), .resp_ready(1'b1),
    .resp_parity(rp8), .resp_id(rid8),
`ifdef XNOR8_PARITY_SCHED_CHECK_EN
    .req0_exp(1'b0), .req1_exp(1'b0), .resp_err(err8),
`endif
    .busy(busy8)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Parity by counting ones over the word
  function automatic logic ref_parity(input logic [63:0] w, input int nbytes);
    int ones = 0;
    for (int i = 0; i < nbytes * 8; i++) ones += int'(w[i]);
    return (ones % 2) == 1;
  endfunction

  // One request/response round; hold > 0 keeps resp_ready low that many cycles in DONE
  task automatic do_req(input bit v0, input bit v1, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input bit e0, input bit e1, input int hold);
    int winner, lat;
    logic [DW-1:0] wd;
    bit we, p_exp;
    @(negedge clk);
    resp_ready = (hold == 0);
    req0_valid = v0; req1_valid = v1;
    req0_data = d0; req1_data = d1;
    req0_exp = e0; req1_exp = e1;
    #1;
    if (v0 && v1) winner = (last_m == 1) ? 0 : 1;
    else winner = v0 ? 0 : 1;
    check_eq("ready0_grant", req0_ready, (winner == 0));
    check_eq("ready1_grant", req1_ready, (winner == 1));
    wd = (winner == 0) ? d0 : d1;
    we = (winner == 0) ? e0 : e1;
    p_exp = ref_parity(64'(wd), NB);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check_eq("busy_run", busy, 1'b1);
    end while (!resp_valid && lat < 40);
    check_eq("resp_latency", lat, NB + 1);
    check_eq("resp_parity", resp_parity, p_exp);
    check_eq("resp_id", resp_id, winner);
`ifdef XNOR8_PARITY_SCHED_CHECK_EN
    check_eq("resp_err", resp_err, p_exp ^ we);
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = DW'($urandom); req1_data = DW'($urandom);
      #1;
      check_eq("hold_valid", resp_valid, 1'b1);
      check_eq("hold_parity", resp_parity, p_exp);
      check_eq("hold_id", resp_id, winner);
      check_eq("hold_ready0", req0_ready, 1'b0);
      check_eq("hold_ready1", req1_ready, 1'b0);
    end
    if (hold > 0) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    last_m = winner;
    check_eq("idle_after_resp", busy, 1'b0);
    check_eq("valid_after_resp", resp_valid, 1'b0);
  endtask

  // Reset pulse during RUN cycle 2 aborts the request
  task automatic do_abort(input logic [DW-1:0] d);
    @(negedge clk);
    req0_valid = 1'b1; req0_data = d;
    #1;
    check_eq("abort_ready", req0_ready, (last_m == 1) || 1'b1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_busy_in_rst", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    last_m = 1;
    check_eq("abort_busy_after", busy, 1'b0);
    for (int k = 0; k < NB + 3; k++) begin
      @(negedge clk);
      check_eq("abort_no_resp", resp_valid, 1'b0);
    end
  endtask

  task automatic run8(input logic [63:0] d);
    int lat;
    @(negedge clk);
    v8 = 1'b1; d8 = d;
    #1;
    check_eq("n8_ready", rdy8, 1'b1);
    @(posedge clk);
    #1;
    v8 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rv8 && lat < 40);
    check_eq("n8_latency", lat, 9);
    check_eq("n8_parity", rp8, ref_parity(d, 8));
    check_eq("n8_id", rid8, 1'b0);
    @(posedge clk);
  endtask

  initial begin
    int r;
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    req0_exp = 1'b0; req1_exp = 1'b0; v8 = 1'b0; d8 = '0;
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_eq("rst_ready0", req0_ready, 1'b0);
    check_eq("rst_ready1", req1_ready, 1'b0);
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_parity", resp_parity, 1'b0);
    check_eq("rst_id", resp_id, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check_eq("no_xfer_in_rst", busy, 1'b0);

    // tie out of reset, then alternate
    do_req(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0, 0);
    do_req(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0, 0);
    do_req(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0, 0);
    // directed single-requester words
    do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 0);
    do_req(1'b1, 1'b0, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 0);
    do_req(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 0);
    do_req(1'b0, 1'b1, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 0);
    // back-pressure in DONE
    do_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 10);
    // abort then tie goes to requester 0
    do_abort(32'h8000_0000);
    do_req(1'b1, 1'b1, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0, 0);
    // expected-bit checking
    do_req(1'b1, 1'b0, 32'h0000_000F, 32'h0, 1'b0, 1'b0, 0);
    do_req(1'b1, 1'b0, 32'h0000_010F, 32'h0, 1'b0, 1'b0, 0);
    do_req(1'b0, 1'b1, 32'h0, 32'h0000_010F, 1'b0, 1'b1, 0);
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 3);
      do_req(r[0], r[1], DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end
    // eight-byte instance
    run8(64'h8000_0000_0000_0001);
    run8(64'h0000_0000_0000_0001);
    for (int i = 0; i < 4; i++) run8({$urandom, $urandom});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xnor8_parity_sched.md
# xnor8_parity_sched

Time-multiplexed parity scheduler that shares a single `xnor8` reduction unit between two requesters. Each request carries an `8*NBYTES`-bit word. The block arbitrates between the requesters round-robin and streams the granted word through `xnor8` one byte per cycle, folding the per-byte results into an accumulator. It returns the word's XOR parity tagged with the requester ID. It sits beside the issue/commit logic as the shared parity resource for register-file and queue-entry protection.

## Interface
- `NBYTES`, default 4: bytes per word. Legal range 2..16. Data width is `8*NBYTES`.
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `req0_valid` in, 1: requester 0 has a word.
- `req0_data` in, `8*NBYTES`: requester 0 word.
- `req0_ready` out, 1: requester 0 word accepted this cycle when valid is also high.
- `req1_valid`, `req1_data`, `req1_ready`: same as the requester 0 ports, for requester 1.
- `resp_valid` out, 1: result available.
- `resp_ready` in, 1: consumer accepts the result.
- `resp_parity` out, 1: XOR of all bits of the accepted word (1 = odd number of ones).
- `resp_id` out, 1: requester that issued the word.
- `busy` out, 1: high in RUN or DONE.
- `resp_err` out, 1: present only with `XNOR8_PARITY_SCHED_CHECK_EN`.
- `req0_exp`, `req1_exp` in, 1: expected parity bits; present only with `XNOR8_PARITY_SCHED_CHECK_EN`.

## Operation
- Instantiates exactly one `xnor8`. Its output `y` is 1 when its byte has an even number of ones.
- Per cycle in RUN, the block computes `acc <= acc ^ ~y`.
- State machine with three states:
  - IDLE: the grant goes to the single valid requester. If both are valid, the grant goes to the requester not served last. `reqN_ready` = (state == IDLE) & grantN & !rst. On a transfer, latch data, ID and (with CHECK_EN) the expected bit. Then clear `acc`, set `idx` to 0 and go to RUN.
  - RUN: drive byte `idx` into `xnor8`, bytes ordered LSB first (`data[7:0]` first). Update `acc` and increment `idx`. After the byte at `idx == NBYTES-1` is folded, go to DONE.
  - DONE: `resp_valid` = 1. `resp_parity`, `resp_id` and `resp_err` are held stable. On `resp_ready`, update last-served to `resp_id` and go to IDLE.
- Only one request is in flight at a time. Both ready outputs are 0 outside IDLE.
- A requester that drops `valid` before being granted loses nothing; the block has no memory of it.
- A `valid` with no grant is simply held off; the requester keeps its data stable.
- Round-robin pointer: reset value is "last served = 1", so requester 0 wins the first tie.
- A word of all zeros gives `resp_parity` = 0.

## Timing
- Reset: the state machine goes to IDLE. `acc`, `idx`, the latched data and last-served (=1) are cleared. `resp_valid`, `resp_parity`, `resp_id`, `busy`, `resp_err` and both ready outputs are 0 while `rst` is high.
- Accept in cycle T. RUN covers cycles T+1 to T+NBYTES. `resp_valid` rises at T+NBYTES+1.
- A response consumed in cycle D lets the block accept a new request at D+1. Best-case throughput is one word per NBYTES+2 cycles.
- `resp_ready` held low keeps DONE and its outputs indefinitely. No new request is accepted during that time.
- `rst` asserted in RUN or DONE aborts the request on the next edge. No response is emitted and the requester must reissue.
- `rst` and `reqN_valid` asserted together: no transfer occurs.
- There is no combinational path from `req*_valid` to `resp_*`. The path from `req*_valid` to `req*_ready` is combinational only through the grant logic.

## Configuration
- `XNOR8_PARITY_SCHED_CHECK_EN` defined:
  - The `req*_exp` inputs are latched with the data.
  - `resp_err` = (`resp_parity` != latched expected bit), valid in DONE and 0 otherwise.
- `XNOR8_PARITY_SCHED_CHECK_EN` undefined: the `req*_exp` and `resp_err` ports do not exist. The block only generates parity.

## Test plan
- Requester 0 sends 0x00000000, `resp_ready`=1. Response: `resp_valid` at T+5, parity 0, id 0. Then 0x00000001 → parity 1, and 0xFFFFFFFF → parity 0.
- Both requesters valid in the same cycle out of reset, data 0x00000003 and 0x00000007. Requester 0 is served first (parity 0, id 0), then requester 1 (parity 1, id 1). The next tie goes to requester 0.
- `resp_ready` held low for 10 cycles in DONE. `resp_valid`, parity and id stay stable. Both ready outputs stay 0. The response completes on the first `resp_ready`=1.
- `rst` pulsed for 1 cycle at RUN cycle 2 with word 0x80000000. No response is emitted. The block returns to IDLE with `busy`=0, and requester 0 wins the next tie.
- With CHECK_EN: 0x0000000F with exp=0 → `resp_err` 0. 0x0000010F with exp=0 → parity 1, `resp_err` 1.
- With `NBYTES`=8, word 0x8000000000000001 → parity 0 at T+9.
